// File: rtl/parking_gate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// parking_pkg : shared state encoding and default sizing for parking_gate_ctrl
// Revision    : 1.0
// ============================================================================
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OPEN      = 2'd1,
    WAIT_PASS = 2'd2,
    CLOSE     = 2'd3
  } gate_state_t;

  localparam int DEF_CAPACITY     = 50;
  localparam int DEF_CNT_BITS     = 6;
  localparam int DEF_OPEN_CYCLES  = 16;
  localparam int DEF_CLOSE_CYCLES = 4;
  localparam int DEF_TMR_BITS     = 5;

endpackage
`default_nettype wire

// File: rtl/parking_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// parking_gate_ctrl_if : lane sensor / gate actuator / occupancy status bundle
// Revision             : 1.0
// ============================================================================
interface parking_gate_ctrl_if
  import parking_pkg::*;
#(
  parameter int CNT_BITS = DEF_CNT_BITS
);
  logic                entry_req;
  logic                exit_req;
  logic                car_passed;
  logic                gate_open;
  logic                dir_in;
  logic                entry_denied;
  logic                timeout;
  logic [CNT_BITS-1:0] occupancy;
  logic                full;
  logic                empty;

  // master = lane sensors / supervisor, slave = the gate controller
  modport master (
    output entry_req, exit_req, car_passed,
    input  gate_open, dir_in, entry_denied, timeout, occupancy, full, empty
  );

  modport slave (
    input  entry_req, exit_req, car_passed,
    output gate_open, dir_in, entry_denied, timeout, occupancy, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/gate_timer.sv
`default_nettype none
// ============================================================================
// gate_timer : loadable down-counter shared by the open-wait and close-settle phases
// Revision   : 1.0
// ============================================================================
module gate_timer #(
  parameter int TMR_BITS = 5
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_i,
  input  logic [TMR_BITS-1:0] load_val_i,
  input  logic                en_i,
  output logic                expired_o
);
  logic [TMR_BITS-1:0] cnt_q;
  logic [TMR_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A load of N yields exactly N enabled cycles, the last of which reports expired
  assign expired_o = en_i && (cnt_q <= TMR_BITS'(1));

endmodule
`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// parking_gate_ctrl : single-lane gate arbiter/sequencer with occupancy tracking
// Revision : 1.0    Option macro GATE_EXIT_PRIORITY_EN: exit always wins ties
// ============================================================================
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int CNT_BITS     = DEF_CNT_BITS,
  parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES,
  parameter int TMR_BITS     = DEF_TMR_BITS
) (
  input logic                clk,
  input logic                n_rst,
  parking_gate_ctrl_if.slave bus
);
  localparam logic [CNT_BITS-1:0] CAP_VAL    = CNT_BITS'(CAPACITY);
  localparam logic [TMR_BITS-1:0] OPEN_LOAD  = TMR_BITS'(OPEN_CYCLES);
  localparam logic [TMR_BITS-1:0] CLOSE_LOAD = TMR_BITS'(CLOSE_CYCLES);

  gate_state_t         state_q, state_d;
  logic [CNT_BITS-1:0] occ_q, occ_d, occ_inc, occ_dec;
  logic                gate_q, gate_d;
  logic                dir_q, dir_d;
  logic                denied_q, denied_d;
  logic                denied_seen_q, denied_seen_d;
  logic                timeout_q, timeout_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;

  logic                entry_ok, exit_ok, grant_in;
  logic                wait_done;
  logic                tmr_load, tmr_en, tmr_expired;
  logic [TMR_BITS-1:0] tmr_val;

  assign entry_ok  = bus.entry_req && !full_q;
  assign exit_ok   = bus.exit_req && !empty_q;
  assign wait_done = (state_q == WAIT_PASS) && (bus.car_passed || tmr_expired);

`ifdef GATE_EXIT_PRIORITY_EN
  assign grant_in = entry_ok && !exit_ok;
`else
  logic rr_last_in_q;

  // Starts as "exit served last" so the first tie goes to entry
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_last_in_q <= 1'b0;
    end else if (wait_done) begin
      rr_last_in_q <= dir_q;
    end
  end

  assign grant_in = entry_ok && (!exit_ok || !rr_last_in_q);
`endif

  assign tmr_en   = (state_q == WAIT_PASS) || (state_q == CLOSE);
  assign tmr_load = (state_q == OPEN) || wait_done;
  assign tmr_val  = (state_q == OPEN) ? OPEN_LOAD : CLOSE_LOAD;

  gate_timer #(
    .TMR_BITS (TMR_BITS)
  ) u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  assign occ_inc = (occ_q >= CAP_VAL) ? CAP_VAL : occ_q + 1'b1;
  assign occ_dec = (occ_q == '0) ? '0 : occ_q - 1'b1;

  always_comb begin
    state_d       = state_q;
    occ_d         = occ_q;
    dir_d         = dir_q;
    gate_d        = 1'b0;
    denied_d      = 1'b0;
    denied_seen_d = (state_q == IDLE) ? denied_seen_q : 1'b0;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.entry_req && full_q && !denied_seen_q) begin
          denied_d      = 1'b1;
          denied_seen_d = 1'b1;
        end
        if (entry_ok || exit_ok) begin
          dir_d   = grant_in;
          state_d = OPEN;
        end
      end
      OPEN: begin
        gate_d  = 1'b1;
        state_d = WAIT_PASS;
      end
      WAIT_PASS: begin
        gate_d = 1'b1;
        // A pass on the expiry cycle still counts and suppresses the timeout
        if (bus.car_passed) begin
          occ_d = dir_q ? occ_inc : occ_dec;
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
        end
        if (wait_done) begin
          gate_d  = 1'b0;
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        if (tmr_expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    full_d  = (occ_d == CAP_VAL);
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      occ_q         <= '0;
      gate_q        <= 1'b0;
      dir_q         <= 1'b0;
      denied_q      <= 1'b0;
      denied_seen_q <= 1'b0;
      timeout_q     <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      occ_q         <= occ_d;
      gate_q        <= gate_d;
      dir_q         <= dir_d;
      denied_q      <= denied_d;
      denied_seen_q <= denied_seen_d;
      timeout_q     <= timeout_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
    end
  end

  assign bus.gate_open    = gate_q;
  assign bus.dir_in       = dir_q;
  assign bus.entry_denied = denied_q;
  assign bus.timeout      = timeout_q;
  assign bus.occupancy    = occ_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// tb_parking_gate_ctrl : directed vector table plus hand-written corner sequences
// Revision             : 1.0
// ============================================================================
module tb_parking_gate_ctrl;
  import parking_pkg::*;

  localparam int CNT_BITS = DEF_CNT_BITS;
  localparam int CAP      = DEF_CAPACITY;

  typedef struct {
    bit en;
    bit ex;
    bit car;
    bit gate;
    bit dir;
    bit den;
    bit to;
    int occ;
    bit full;
    bit empty;
  } vec_t;

  logic clk;
  logic n_rst;
  vec_t vq[$];
  int   n_checks;
  int   n_errors;
  int   occ_m;
  bit   last_in_m;

  parking_gate_ctrl_if #(.CNT_BITS(CNT_BITS)) bus ();

  parking_gate_ctrl #(
    .CAPACITY     (CAP),
    .CNT_BITS     (CNT_BITS),
    .OPEN_CYCLES  (DEF_OPEN_CYCLES),
    .CLOSE_CYCLES (DEF_CLOSE_CYCLES),
    .TMR_BITS     (DEF_TMR_BITS)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input bit exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input logic [CNT_BITS-1:0] act, input int exp);
    n_checks++;
    if (act !== CNT_BITS'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit en, input bit ex, input bit car, input bit gate, input bit dir,
                     input bit den, input bit to, input int occ, input bit full, input bit empty);
    vec_t v;
    v.en = en; v.ex = ex; v.car = car; v.gate = gate; v.dir = dir;
    v.den = den; v.to = to; v.occ = occ; v.full = full; v.empty = empty;
    vq.push_back(v);
  endtask

  function automatic bit tie_dir();
`ifdef GATE_EXIT_PRIORITY_EN
    return 1'b0;
`else
    return !last_in_m;
`endif
  endfunction

  // Request a side, wait for the gate, check direction, pulse car_passed.
  task automatic serve(input bit e, input bit x, input bit hold, input bit exp_dir);
    bit seen;
    seen = 1'b0;
    bus.entry_req = e;
    bus.exit_req  = x;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.gate_open === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk1("gate_open_wait", bus.gate_open, 1'b1);
      bus.entry_req = 1'b0;
      bus.exit_req  = 1'b0;
      repeat (DEF_OPEN_CYCLES + DEF_CLOSE_CYCLES + 4) tick();
      return;
    end
    chk1("serve_dir", bus.dir_in, exp_dir);
    bus.car_passed = 1'b1;
    if (!hold) begin
      bus.entry_req = 1'b0;
      bus.exit_req  = 1'b0;
    end
    tick();
    bus.car_passed = 1'b0;
    if (exp_dir) begin
      if (occ_m < CAP) occ_m++;
    end else begin
      if (occ_m > 0) occ_m--;
    end
    last_in_m = exp_dir;
    chkn("serve_occ", bus.occupancy, occ_m);
    chk1("serve_gate_closed", bus.gate_open, 1'b0);
    if (!hold) repeat (DEF_CLOSE_CYCLES) tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.entry_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b0;
    n_rst          = 1'b0;

    // Entry sequence, CLOSE hold length, car_passed ignored in CLOSE and IDLE
    add(1,0,0, 0,1,0,0,0,0,1);
    add(0,0,0, 1,1,0,0,0,0,1);
    repeat (2) add(0,0,0, 1,1,0,0,0,0,1);
    add(0,0,1, 0,1,0,0,1,0,0);
    repeat (5) add(1,0,0, 0,1,0,0,1,0,0);
    add(0,0,0, 1,1,0,0,1,0,0);
    add(0,0,1, 0,1,0,0,2,0,0);
    add(0,0,1, 0,1,0,0,2,0,0);
    repeat (3) add(0,0,0, 0,1,0,0,2,0,0);
    add(0,0,1, 0,1,0,0,2,0,0);
    // Exit grant; car_passed on the exact expiry cycle counts, no timeout
    add(0,1,0, 0,0,0,0,2,0,0);
    add(0,0,0, 1,0,0,0,2,0,0);
    repeat (15) add(0,0,0, 1,0,0,0,2,0,0);
    add(0,0,1, 0,0,0,0,1,0,0);
    repeat (4) add(0,0,0, 0,0,0,0,1,0,0);
    // Entry grant with no car: timeout 16 cycles after WAIT_PASS entry
    add(1,0,0, 0,1,0,0,1,0,0);
    add(0,0,0, 1,1,0,0,1,0,0);
    repeat (15) add(0,0,0, 1,1,0,0,1,0,0);
    add(0,0,0, 0,1,0,1,1,0,0);
    repeat (4) add(0,0,0, 0,1,0,0,1,0,0);

    repeat (3) tick();
    chk1("rst_gate_open", bus.gate_open, 1'b0);
    chk1("rst_dir_in", bus.dir_in, 1'b0);
    chk1("rst_entry_denied", bus.entry_denied, 1'b0);
    chk1("rst_timeout", bus.timeout, 1'b0);
    chkn("rst_occupancy", bus.occupancy, 0);
    chk1("rst_full", bus.full, 1'b0);
    chk1("rst_empty", bus.empty, 1'b1);
    n_rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      bus.entry_req  = vq[i].en;
      bus.exit_req   = vq[i].ex;
      bus.car_passed = vq[i].car;
      tick();
      chk1($sformatf("v%0d_gate_open", i), bus.gate_open, vq[i].gate);
      chk1($sformatf("v%0d_dir_in", i), bus.dir_in, vq[i].dir);
      chk1($sformatf("v%0d_entry_denied", i), bus.entry_denied, vq[i].den);
      chk1($sformatf("v%0d_timeout", i), bus.timeout, vq[i].to);
      chkn($sformatf("v%0d_occupancy", i), bus.occupancy, vq[i].occ);
      chk1($sformatf("v%0d_full", i), bus.full, vq[i].full);
      chk1($sformatf("v%0d_empty", i), bus.empty, vq[i].empty);
    end
    bus.entry_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b0;
    occ_m     = 1;
    last_in_m = 1'b1;

    // Build up to 10 cars, then hold both requests and watch tie-breaking
    repeat (9) serve(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) serve(1'b1, 1'b1, 1'b1, tie_dir());
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    repeat (DEF_CLOSE_CYCLES) tick();

    // Fill the lot, then check the single entry_denied pulse while full
    while (occ_m < CAP) serve(1'b1, 1'b0, 1'b0, 1'b1);
    chk1("full_at_cap", bus.full, 1'b1);
    bus.entry_req = 1'b1;
    tick();
    chk1("denied_pulse", bus.entry_denied, 1'b1);
    chk1("denied_no_gate", bus.gate_open, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk1("denied_once", bus.entry_denied, 1'b0);
      chk1("denied_gate_shut", bus.gate_open, 1'b0);
      chkn("denied_occ", bus.occupancy, CAP);
    end
    bus.entry_req = 1'b0;
    serve(1'b0, 1'b1, 1'b0, 1'b0);
    chk1("not_full_after_exit", bus.full, 1'b0);

    // Fresh reset, 7 cars, then reset while the gate is open
    #2 n_rst = 1'b0;
    #1 n_rst = 1'b1;
    occ_m     = 0;
    last_in_m = 1'b0;
    tick();
    repeat (7) serve(1'b1, 1'b0, 1'b0, 1'b1);
    bus.entry_req = 1'b1;
    repeat (2) tick();
    chk1("pre_reset_gate", bus.gate_open, 1'b1);
    bus.entry_req = 1'b0;
    tick();
    #2 n_rst = 1'b0;
    #1;
    chk1("async_rst_gate", bus.gate_open, 1'b0);
    chkn("async_rst_occ", bus.occupancy, 0);
    chk1("async_rst_empty", bus.empty, 1'b1);
    chk1("async_rst_dir", bus.dir_in, 1'b0);
    tick();
    n_rst = 1'b1;
    occ_m = 0;
    bus.entry_req = 1'b1;
    tick();
    chk1("post_rst_gate_lat1", bus.gate_open, 1'b0);
    tick();
    chk1("post_rst_gate_lat2", bus.gate_open, 1'b1);
    chk1("post_rst_dir", bus.dir_in, 1'b1);
    bus.entry_req  = 1'b0;
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    chkn("post_rst_occ", bus.occupancy, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
